// File: rtl/riscv_sim_pkg.sv
// riscv_sim_pkg: shared widths, default base address and FSM states for the data-memory responder
package riscv_sim_pkg;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W = 4;
  localparam logic [WORD_W-1:0] DEF_BASE_ADDR = 32'h0000_1000;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
endpackage

// File: rtl/riscv_dmem_array.sv
// riscv_dmem_array: single-port synchronous word RAM with per-byte write enables
module riscv_dmem_array
  import riscv_sim_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  // one access per enabled cycle: a lane-masked write, or a registered read that holds until the next read
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < BE_W; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end else if (en) rdata <= mem[addr];
  end
endmodule

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: single-outstanding data-memory responder with a fixed wait latency and access-fault checks
module riscv_dmem_responder
  import riscv_sim_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [WORD_W-1:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
  dmem_state_t state, state_nx;
  logic [3:0] cnt;
  logic we_q;
  logic [WORD_W-1:0] addr_q, wdata_q, off, ram_q;
  logic [BE_W-1:0] be_q;
  logic idle, accept, go_resp, a_we, a_err;
  logic [WORD_W-1:0] a_addr, a_wdata;
  logic [BE_W-1:0] a_be;
  assign idle = state == IDLE;
  assign accept = idle && req_valid;
  // with zero wait the access happens on the accepting edge, so the live request drives the RAM while idle
  assign a_we = idle ? req_we : we_q;
  assign a_addr = idle ? req_addr : addr_q;
  assign a_wdata = idle ? req_wdata : wdata_q;
  assign a_be = idle ? req_be : be_q;
  assign off = a_addr - BASE_ADDR;
  assign a_err = |a_addr[1:0] || a_addr < BASE_ADDR || (off >> 2) >= DEPTH_WORDS || a_be == '0;
  assign go_resp = idle ? (req_valid && WAIT_CYCLES == 0) : (state == WAIT && cnt == 4'd0);
  // state register; reset discards any in-flight request
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: IDLE accepts, WAIT counts down, RESP holds until the core consumes it
  always_comb begin
    state_nx = idle ? (req_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
             : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT)
             : (rsp_ready ? IDLE : RESP);
  end
  // outputs; fault status and data come from the captured request so they stay stable in RESP
  always_comb begin
    req_ready = idle && !reset;
    rsp_valid = state == RESP;
    rsp_err = rsp_valid && a_err;
    rsp_rdata = (rsp_valid && !a_err && !we_q) ? ram_q : '0;
  end
  // capture the accepted request for the wait and response phases
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else if (accept) begin
      we_q <= req_we;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
      be_q <= req_be;
    end
  // wait counter: loaded on acceptance, counts down to zero while waiting
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= 4'd0;
    else if (accept) cnt <= CNT_INIT;
    else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  riscv_dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clk  (clk),
    .en   (go_resp && !a_err && !reset),
    .we   (a_we),
    .be   (a_be),
    .addr (off[AW+1:2]),
    .wdata(a_wdata),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb_riscv_dmem_responder: directed and randomized checks of two responder configurations against a word-map model
module tb_riscv_dmem_responder;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 1'b0, reset = 1'b1;
  logic req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_be = '0;
  logic rv0 = 1'b0, rv1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
  logic rdy0, rdy1, vld0, vld1, err0, err1;
  logic [31:0] rd0, rd1;
  logic sel = 1'b0;
  logic o_rdy, o_vld, o_err;
  logic [31:0] o_rd;
  int passed = 0, total = 0;
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  assign o_rdy = sel ? rdy1 : rdy0;
  assign o_vld = sel ? vld1 : vld0;
  assign o_err = sel ? err1 : err0;
  assign o_rd  = sel ? rd1 : rd0;

  riscv_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) dut_w2 (
    .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld0),
    .rsp_ready(rr0), .rsp_rdata(rd0), .rsp_err(err0));

  riscv_dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut_w0 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld1),
    .rsp_ready(rr1), .rsp_rdata(rd1), .rsp_err(err1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic setv(input logic v);
    if (sel) rv1 = v; else rv0 = v;
  endtask

  task automatic setr(input logic v);
    if (sel) rr1 = v; else rr0 = v;
  endtask

  // one full request/response exchange with the expected result taken from the word map
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int stall);
    int k, key, dep, wc;
    longint off;
    logic e;
    logic [31:0] d, nw, held;
    dep = sel ? 16 : 256;
    wc = sel ? 0 : 2;
    off = longint'(a) - longint'(BASE);
    e = (a % 4 != 0) || off < 0 || off / 4 >= longint'(dep) || be == 4'h0;
    key = int'(sel) * 65536 + (e ? 0 : int'(off / 4));
    nw = (!e && mdl.exists(key)) ? mdl[key] : 'x;
    d = (e || we) ? 32'h0 : nw;
    if (!e && we)
      for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    setv(1'b1);
    chk("req_ready_idle", 32'(o_rdy), 32'd1);
    @(posedge clk); #1;
    setv(1'b0);
    if (!e && we) mdl[key] = nw;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      chk("req_ready_busy", 32'(o_rdy), 32'd0);
    end while (!o_vld && k < 40);
    chk("latency", 32'(k), 32'(wc + 1));
    if (o_vld) begin
      chk("rsp_err", 32'(o_err), 32'(e));
      if (!$isunknown(d)) chk("rsp_rdata", o_rd, d);
      held = o_rd;
      for (int s = 0; s < stall; s++) begin
        setv(1'b1);
        @(negedge clk);
        chk("stall_valid", 32'(o_vld), 32'd1);
        chk("stall_rdata", o_rd, held);
        chk("stall_ready", 32'(o_rdy), 32'd0);
      end
      setr(1'b1);
      @(posedge clk); #1;
      setr(1'b0);
      setv(1'b0);
      chk("drained_valid", 32'(o_vld), 32'd0);
      chk("drained_ready", 32'(o_rdy), 32'd1);
    end
  endtask

  initial begin
    int idx, mode, dep;
    logic [31:0] a;
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("reset_ready", 32'(o_rdy), 32'd0);
      chk("reset_valid", 32'(o_vld), 32'd0);
      chk("reset_err", 32'(o_err), 32'd0);
      chk("reset_rdata", o_rd, 32'd0);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    sel = 1'b0; #0 chk("post_reset_ready_w2", 32'(o_rdy), 32'd1);
    sel = 1'b1; #0 chk("post_reset_ready_w0", 32'(o_rdy), 32'd1);
    sel = 1'b0;
    txn(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 32'h1000, 32'h0, 4'hF, 0);
    txn(1'b1, 32'h1004, 32'h11223344, 4'hF, 0);
    txn(1'b1, 32'h1004, 32'h0000AA00, 4'b0010, 0);
    txn(1'b0, 32'h1004, 32'h0, 4'hF, 0);
    txn(1'b0, 32'h1002, 32'h0, 4'hF, 0);
    txn(1'b0, 32'h0FFC, 32'h0, 4'hF, 0);
    txn(1'b0, BASE + 32'(4 * 256), 32'h0, 4'hF, 0);
    txn(1'b1, 32'h1000, 32'h12345678, 4'h0, 0);
    txn(1'b0, 32'h1000, 32'h0, 4'hF, 0);
    txn(1'b0, 32'h1004, 32'h0, 4'hF, 5);
    txn(1'b0, 32'h1000, 32'h0, 4'hF, 0);
    txn(1'b1, 32'h1008, 32'h55AA_0FF0, 4'hF, 0);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h1008; req_wdata = 32'h0BAD_F00D; req_be = 4'hF;
    setv(1'b1);
    @(posedge clk); #1;
    setv(1'b0);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("midwait_reset_valid", 32'(o_vld), 32'd0);
    chk("midwait_reset_err", 32'(o_err), 32'd0);
    chk("midwait_reset_rdata", o_rd, 32'd0);
    chk("midwait_reset_ready", 32'(o_rdy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("midwait_post_ready", 32'(o_rdy), 32'd1);
    txn(1'b0, 32'h1008, 32'h0, 4'hF, 0);
    sel = 1'b1;
    txn(1'b1, 32'h1010, 32'hCAFE_F00D, 4'hF, 0);
    txn(1'b0, 32'h1010, 32'h0, 4'hF, 0);
    txn(1'b1, BASE + 32'(4 * 15), 32'hA5A5_5A5A, 4'hF, 0);
    txn(1'b0, BASE + 32'(4 * 15), 32'h0, 4'hF, 2);
    txn(1'b0, BASE + 32'(4 * 16), 32'h0, 4'hF, 0);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 16; i++) txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0);
    end
    for (int n = 0; n < 80; n++) begin
      sel = 1'($urandom_range(0, 1));
      dep = sel ? 16 : 256;
      idx = $urandom_range(0, 15);
      mode = $urandom_range(0, 9);
      a = BASE + 32'(4 * idx);
      if (mode == 0) a = a + 32'($urandom_range(1, 3));
      else if (mode == 1) a = BASE - 32'(4 * $urandom_range(1, 3));
      else if (mode == 2) a = BASE + 32'(4 * (dep + $urandom_range(0, 3)));
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired after %0d/%0d checks", passed, total);
    $fatal(1);
  end
endmodule
